// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
// Optional macro FIFO_FWFT_EN selects first-word fall-through output; without
// it, reads are registered with one cycle of latency.
//
// Handshake: a write is taken at a rising edge when WR=1 and FULL=0; a read is
// taken when RD=1 and EMPTY=0. Both use the flags as they stand before the
// edge, so a same-cycle read never makes room for a write and a same-cycle
// write never feeds a read. A refused request raises OVER/UNDER for one cycle.
module fifo_param #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WR,
  input  logic                     RD,
  input  logic [WIDTH-1:0]         DIN,
  output logic [WIDTH-1:0]         DOUT,
  output logic                     VALID,
  output logic                     FULL,
  output logic                     almostFULL,
  output logic                     EMPTY,
  output logic                     almostEMPTY,
  output logic                     OVER,
  output logic                     UNDER,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Thresholds sized to the count so flag decodes compare like widths.
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  // Illegal configurations are rejected at elaboration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("fifo_param: AFULL_TH out of range 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_param: AEMPTY_TH out of range 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             wr_ok;
  logic             rd_ok;

  // Accept decisions use the registered flags only.
  assign wr_ok = WR & ~FULL;
  assign rd_ok = RD & ~EMPTY;

  // Flags are pure decodes of the registered occupancy.
  assign FULL        = (count == DEPTH_C);
  assign EMPTY       = (count == '0);
  assign almostFULL  = (count >= AFULL_C);
  assign almostEMPTY = (count <= AEMPTY_C);
  assign COUNT       = count;

  // Storage is never reset; after reset the pointers make old entries unreachable.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wptr] <= DIN;
    end
  end

  // Pointers, occupancy and the error pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      OVER  <= 1'b0;
      UNDER <= 1'b0;
    end else begin
      OVER  <= WR & FULL;
      UNDER <= RD & EMPTY;
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_FWFT_EN
  // Head of queue is always presented; RD acknowledges and pops it.
  assign DOUT  = mem[rptr];
  assign VALID = ~EMPTY;
`else
  logic [WIDTH-1:0] dout_r;
  logic             valid_r;

  // Registered read port: data and VALID appear the cycle after acceptance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= rd_ok;
      if (rd_ok) begin
        dout_r <= mem[rptr];
      end
    end
  end

  assign DOUT  = dout_r;
  assign VALID = valid_r;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed checks on a default 16x8 fifo_param plus a
// scoreboarded random run on a 32x16 instance with custom thresholds.
module tb_fifo_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst, wr, rd;
  logic [15:0] din, dout;
  logic        valid, full, afull, empty, aempty, over, under;
  logic [3:0]  count;

  // 32x16 instance
  logic        rst_b, wr_b, rd_b;
  logic [31:0] din_b, dout_b;
  logic        valid_b, full_b, afull_b, empty_b, aempty_b, over_b, under_b;
  logic [4:0]  count_b;

  fifo_param u_dut (
    .CLK(clk), .RST(rst), .WR(wr), .RD(rd), .DIN(din), .DOUT(dout),
    .VALID(valid), .FULL(full), .almostFULL(afull), .EMPTY(empty),
    .almostEMPTY(aempty), .OVER(over), .UNDER(under), .COUNT(count)
  );

  fifo_param #(.WIDTH(32), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(3)) u_dut_b (
    .CLK(clk), .RST(rst_b), .WR(wr_b), .RD(rd_b), .DIN(din_b), .DOUT(dout_b),
    .VALID(valid_b), .FULL(full_b), .almostFULL(afull_b), .EMPTY(empty_b),
    .almostEMPTY(aempty_b), .OVER(over_b), .UNDER(under_b), .COUNT(count_b)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rst_b = 1'b1;
    wr = 0; rd = 0; din = '0;
    wr_b = 0; rd_b = 0; din_b = '0;
    tick(); tick();
    rst = 1'b0; rst_b = 1'b0;
    tick();
  endtask

  task automatic write_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr = 1'b1; din = base + 16'(i);
      tick();
    end
    wr = 1'b0;
  endtask

  // Random traffic on the 32x16 instance against a model occupancy.
  task automatic random_run(input int cycles);
    int  mcount;
    bit  w, r, w_ok, r_ok;
    logic [31:0] d, head;
    mcount = 0;
    for (int c = 0; c < cycles; c++) begin
      if (c < cycles / 2) begin
        w = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0);
      end
      d = $urandom;
      w_ok = w && (mcount != 16);
      r_ok = r && (mcount != 0);
`ifdef FIFO_FWFT_EN
      check("rnd_valid", 32'(valid_b), 32'(mcount != 0));
      if (mcount != 0) check("rnd_head", dout_b, exp_q[0]);
`endif
      wr_b = w; rd_b = r; din_b = d;
      tick();
      head = 32'h0;
      if (r_ok) head = exp_q.pop_front();
      if (w_ok) exp_q.push_back(d);
      if (w_ok && !r_ok) mcount++;
      if (r_ok && !w_ok) mcount--;
`ifndef FIFO_FWFT_EN
      check("rnd_valid", 32'(valid_b), 32'(r_ok));
      if (r_ok) check("rnd_dout", dout_b, head);
`endif
      check("rnd_count", 32'(count_b), 32'(mcount));
      check("rnd_aempty", 32'(aempty_b), 32'(mcount <= 3));
      check("rnd_afull", 32'(afull_b), 32'(mcount >= 12));
      check("rnd_full", 32'(full_b), 32'(mcount == 16));
      check("rnd_empty", 32'(empty_b), 32'(mcount == 0));
      check("rnd_over", 32'(over_b), 32'(w && !w_ok));
      check("rnd_under", 32'(under_b), 32'(r && !r_ok));
    end
    wr_b = 0; rd_b = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_aempty", 32'(aempty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_afull", 32'(afull), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_over", 32'(over), 32'd0);
    check("rst_under", 32'(under), 32'd0);

`ifndef FIFO_FWFT_EN
    check("rst_dout", 32'(dout), 32'd0);

    // fill with 0x0001..0x0008
    for (int i = 1; i <= 8; i++) begin
      wr = 1'b1; din = 16'(i);
      tick();
      check("fill_count", 32'(count), 32'(i));
      check("fill_afull", 32'(afull), 32'(i >= 7));
      check("fill_full", 32'(full), 32'(i == 8));
      check("fill_empty", 32'(empty), 32'd0);
      check("fill_aempty", 32'(aempty), 32'(i <= 1));
      check("fill_over", 32'(over), 32'd0);
    end

    // write while full
    din = 16'h0009;
    tick();
    wr = 1'b0;
    check("ovf_over", 32'(over), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    tick();
    check("ovf_pulse_end", 32'(over), 32'd0);

    // drain in order
    rd = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("drain_valid", 32'(valid), 32'd1);
      check("drain_dout", 32'(dout), 32'(i));
      check("drain_count", 32'(count), 32'(8 - i));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // read while empty
    tick();
    check("udf_under", 32'(under), 32'd1);
    check("udf_valid", 32'(valid), 32'd0);
    check("udf_dout_hold", 32'(dout), 32'h0008);

    // simultaneous WR/RD on empty: write proceeds, read refused
    wr = 1'b1; din = 16'h1111;
    tick();
    wr = 1'b0;
    check("wr_rd_empty_under", 32'(under), 32'd1);
    check("wr_rd_empty_count", 32'(count), 32'd1);
    check("wr_rd_empty_empty", 32'(empty), 32'd0);
    check("wr_rd_empty_valid", 32'(valid), 32'd0);
    tick();
    rd = 1'b0;
    check("rd_1111_dout", 32'(dout), 32'h1111);
    check("rd_1111_valid", 32'(valid), 32'd1);
    check("rd_1111_under", 32'(under), 32'd0);
    check("rd_1111_count", 32'(count), 32'd0);

    // simultaneous WR/RD on full: read proceeds, write refused
    write_words(16'h00A0, 8);
    check("refill_full", 32'(full), 32'd1);
    wr = 1'b1; rd = 1'b1; din = 16'h5555;
    tick();
    wr = 1'b0;
    check("wr_rd_full_over", 32'(over), 32'd1);
    check("wr_rd_full_valid", 32'(valid), 32'd1);
    check("wr_rd_full_dout", 32'(dout), 32'h00A0);
    check("wr_rd_full_count", 32'(count), 32'd7);
    check("wr_rd_full_full", 32'(full), 32'd0);
    check("wr_rd_full_afull", 32'(afull), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("tail_dout", 32'(dout), 32'(16'h00A0 + 16'(i)));
    end
    tick();
    rd = 1'b0;
    check("no_5555_under", 32'(under), 32'd1);
    check("no_5555_dout", 32'(dout), 32'h00A7);
`else
    // fall-through: head appears without RD
    wr = 1'b1; din = 16'h00AA;
    tick();
    wr = 1'b0;
    check("fwft_valid", 32'(valid), 32'd1);
    check("fwft_dout", 32'(dout), 32'h00AA);
    check("fwft_count", 32'(count), 32'd1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("fwft_pop_valid", 32'(valid), 32'd0);
    check("fwft_pop_empty", 32'(empty), 32'd1);
    write_words(16'h0011, 2);
    check("fwft_head0", 32'(dout), 32'h0011);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("fwft_head1", 32'(dout), 32'h0012);
    check("fwft_head1_valid", 32'(valid), 32'd1);
    rd = 1'b1;
    tick();
    tick();
    rd = 1'b0;
    check("fwft_under", 32'(under), 32'd1);
`endif

    // 32x16 random run with scoreboard
    random_run(60);

    // mid-run asynchronous reset
    exp_q.delete();
    rst_b = 1'b1; tick(); rst_b = 1'b0; tick();
    wr_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din_b = 32'hC000_0000 + 32'(i);
      tick();
    end
    wr_b = 1'b0;
    check("pre_arst_count", 32'(count_b), 32'd5);
    #2;
    rst_b = 1'b1;
    #1;
    check("arst_count", 32'(count_b), 32'd0);
    check("arst_empty", 32'(empty_b), 32'd1);
    check("arst_aempty", 32'(aempty_b), 32'd1);
    check("arst_valid", 32'(valid_b), 32'd0);
    tick();
    rst_b = 1'b0;
    wr_b = 1'b1; din_b = 32'hDEAD_BEEF;
    tick();
    wr_b = 1'b0; rd_b = 1'b1;
    tick();
    rd_b = 1'b0;
`ifndef FIFO_FWFT_EN
    check("post_arst_dout", dout_b, 32'hDEAD_BEEF);
`endif
    check("post_arst_count", 32'(count_b), 32'd0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
